fifo_arb_tx: RTL and testbench

Transmit-side packet arbiter for the host FIFO link. It merges two client transmit FIFOs into the single host output FIFO and keeps packets atomic: once a client's header word is forwarded, all of that packet's payload words follow before any other client is served. Clients with pending packets are served round-robin. The block sits between the client TX FIFOs and the host link TX FIFO. It is the transmit counterpart of the RX arbiter, and uses the same header count-field convention.

---
 rtl/fifo_arb_tx.sv | 179 +++++++++++++++++
 tb/tb_fifo_arb_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arb_tx.sv
// fifo_arb_tx: transmit-side packet arbiter for the host FIFO link.
//
// Merges two client TX FIFOs into the single host output FIFO. Packets are atomic. Once a
// client's header has been forwarded, all of its payload words follow before the other
// client is served. Pending clients are served round-robin.
//
// Header word: payload count N = (header & CNTMASK) >> CSHIFT, where N is 0..7.
//
// Ports:
//   CLK          rising-edge clock
//   RESETn       asynchronous active-low reset
//   c1_rden      read strobe to client 1 FIFO (data returns the next cycle)
//   c1_rdempty   client 1 FIFO empty
//   c1_rddata    client 1 read data
//   c2_rden      read strobe to client 2 FIFO
//   c2_rdempty   client 2 FIFO empty
//   c2_rddata    client 2 read data
//   fifo_wren    write strobe to host output FIFO
//   fifo_wrfull  host output FIFO full
//   fifo_wrdata  write data to host output FIFO
//   gnt          one-hot owner (bit0 = c1, bit1 = c2), 00 when idle
//   busy         packet in progress (state not idle)

module fifo_arb_tx #(
    parameter int unsigned       DWIDTH  = 8,
    parameter logic [DWIDTH-1:0] CNTMASK = DWIDTH'(8'h70)
) (
    input  logic              CLK,
    input  logic              RESETn,

    output logic              c1_rden,
    input  logic              c1_rdempty,
    input  logic [DWIDTH-1:0] c1_rddata,

    output logic              c2_rden,
    input  logic              c2_rdempty,
    input  logic [DWIDTH-1:0] c2_rddata,

    output logic              fifo_wren,
    input  logic              fifo_wrfull,
    output logic [DWIDTH-1:0] fifo_wrdata,

    output logic [1:0]        gnt,
    output logic              busy
);

    // Bit index of the lowest set bit of the count mask.
    function automatic int unsigned low_bit(input logic [DWIDTH-1:0] m);
        int unsigned res;
        res = 0;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (m[i]) begin
                res = i;
            end
        end
        return res;
    endfunction

    localparam int unsigned CSHIFT = low_bit(CNTMASK);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [2:0]        rem_q, rem_d;
    logic              last_q, last_d;      // 0: c1 finished last, 1: c2 finished last
    logic              rd_pend_q, rd_pend_d; // a read was issued last cycle; write it now

    logic [1:0]        req;
    logic [1:0]        pick;
    logic [1:0]        rd_req;
    logic              owner_req;
    logic [DWIDTH-1:0] sel_data;
    logic [2:0]        hdr_cnt;

    assign req       = {~c2_rdempty, ~c1_rdempty};
    assign owner_req = |(gnt_q & req);

    // Round-robin pick: on a tie the client that did not finish last wins.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_q ? 2'b01 : 2'b10;
        end
    end

    // Read data is selected by the registered owner; gnt is 00 in idle and reset, giving 0.
    always_comb begin
        sel_data = '0;
        unique case (gnt_q)
            2'b01:   sel_data = c1_rddata;
            2'b10:   sel_data = c2_rddata;
            default: sel_data = '0;
        endcase
    end

    assign hdr_cnt = 3'((sel_data & CNTMASK) >> CSHIFT);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rem_d     = rem_q;
        last_d    = last_q;
        rd_pend_d = 1'b0;
        rd_req    = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_wrfull && (req != 2'b00)) begin
                    rd_req    = pick;
                    gnt_d     = pick;
                    rd_pend_d = 1'b1;
                    state_d   = ST_HDR;
                end
            end

            // The header read returns this cycle and is written straight through.
            ST_HDR: begin
                rem_d = hdr_cnt;
                if (hdr_cnt == 3'd0) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                end else begin
                    state_d = ST_PAY;
                end
            end

            // Alternate read and write so only one read is ever outstanding; full sampled
            // at read issue therefore guarantees room for the resulting write.
            ST_PAY: begin
                if (rd_pend_q) begin
                    rem_d = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = ST_IDLE;
                        gnt_d   = 2'b00;
                        last_d  = gnt_q[1];
                    end
                end else if (owner_req && !fifo_wrfull && (rem_q != 3'd0)) begin
                    rd_req    = gnt_q;
                    rd_pend_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            rem_q     <= 3'd0;
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rem_q     <= rem_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Read strobes are combinational from idle-state requests, so gate them with reset to
    // keep them low while reset is held.
    assign c1_rden     = rd_req[0] & RESETn;
    assign c2_rden     = rd_req[1] & RESETn;
    assign fifo_wren   = rd_pend_q;
    assign fifo_wrdata = sel_data;
    assign gnt         = gnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_arb_tx.sv
// Directed bench for fifo_arb_tx. Client FIFOs are modelled as queues that return data the
// cycle after a read strobe; every host write is logged with its cycle number.

module tb_fifo_arb_tx;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       c1_rden, c2_rden, c1_rdempty, c2_rdempty;
    logic [7:0] c1_rddata, c2_rddata;
    logic       fifo_wren, fifo_wrfull;
    logic [7:0] fifo_wrdata;
    logic [1:0] gnt;
    logic       busy;

    fifo_arb_tx #(
        .DWIDTH  (8),
        .CNTMASK (8'h70)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .c1_rden     (c1_rden),
        .c1_rdempty  (c1_rdempty),
        .c1_rddata   (c1_rddata),
        .c2_rden     (c2_rden),
        .c2_rdempty  (c2_rdempty),
        .c2_rddata   (c2_rddata),
        .fifo_wren   (fifo_wren),
        .fifo_wrfull (fifo_wrfull),
        .fifo_wrdata (fifo_wrdata),
        .gnt         (gnt),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Client FIFO models.
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic       pend1 = 1'b0;
    logic       pend2 = 1'b0;

    task automatic upd_empty();
        c1_rdempty = (q1.size() == 0);
        c2_rdempty = (q2.size() == 0);
    endtask

    task automatic push1(input logic [7:0] d);
        q1.push_back(d);
        upd_empty();
    endtask

    task automatic push2(input logic [7:0] d);
        q2.push_back(d);
        upd_empty();
    endtask

    always @(posedge CLK) begin
        #1;
        if (pend1 && q1.size() > 0) c1_rddata = q1.pop_front();
        if (pend2 && q2.size() > 0) c2_rddata = q2.pop_front();
        pend1 = 1'b0;
        pend2 = 1'b0;
        upd_empty();
    end

    // Output log and protocol checks, sampled on the falling edge.
    logic [7:0] out_data[$];
    int         out_cyc[$];
    logic [1:0] out_gnt[$];
    logic       out_busy[$];
    int         hdr_cyc[$];
    logic [1:0] hdr_who[$];
    int         idle_cyc[$];
    logic       busy_prev = 1'b0;
    logic [7:0] exp_q[$];

    always @(negedge CLK) begin
        if (RESETn) begin
            if (fifo_wren) begin
                out_data.push_back(fifo_wrdata);
                out_cyc.push_back(cyc);
                out_gnt.push_back(gnt);
                out_busy.push_back(busy);
            end
            if (c1_rden || c2_rden) begin
                if (!busy) begin
                    hdr_cyc.push_back(cyc);
                    hdr_who.push_back({c2_rden, c1_rden});
                end
                check_eq("rd_excl", 32'(c1_rden & c2_rden), 0);
                check_eq("rd_with_wr", 32'(fifo_wren), 0);
                check_eq("rd_while_full", 32'(fifo_wrfull), 0);
                check_eq("rd_while_empty",
                         32'((c1_rden & c1_rdempty) | (c2_rden & c2_rdempty)), 0);
                if (busy) check_eq("rd_owner", 32'({c2_rden, c1_rden}), 32'(gnt));
            end
            if (busy_prev && !busy) idle_cyc.push_back(cyc);
            busy_prev = busy;
            pend1 = c1_rden;
            pend2 = c2_rden;
        end
    end

    task automatic clear_logs();
        out_data.delete();
        out_cyc.delete();
        out_gnt.delete();
        out_busy.delete();
        hdr_cyc.delete();
        hdr_who.delete();
        idle_cyc.delete();
        exp_q.delete();
        busy_prev = 1'b0;
    endtask

    task automatic at_pos();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_outs(input int k, input int budget);
        int n;
        n = 0;
        while (n < budget && out_data.size() < k) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check_eq("outs_seen", 32'(out_data.size() >= k), 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (n < budget && quiet < 3) begin
            @(negedge CLK);
            #1;
            n++;
            if (!busy && !fifo_wren && q1.size() == 0 && q2.size() == 0) quiet++;
            else quiet = 0;
        end
        check_eq("settle", 32'(quiet >= 3), 1);
    endtask

    task automatic compare_out(input string tag);
        check_eq({tag, "_len"}, 32'(out_data.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_data.size(); i++) begin
            check_eq(tag, 32'(out_data[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_c1_rden"}, 32'(c1_rden), 0);
        check_eq({tag, "_c2_rden"}, 32'(c2_rden), 0);
        check_eq({tag, "_wren"}, 32'(fifo_wren), 0);
        check_eq({tag, "_wrdata"}, 32'(fifo_wrdata), 0);
        check_eq({tag, "_gnt"}, 32'(gnt), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic enter_reset();
        RESETn = 1'b0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        q1.delete();
        q2.delete();
        upd_empty();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        RESETn      = 1'b1;
        fifo_wrfull = 1'b0;
        c1_rddata   = 8'h00;
        c2_rddata   = 8'h00;
        upd_empty();
        #1;
        enter_reset();

        // Reset state, with c1 already holding a packet: no strobe may escape.
        push1(8'h20);
        push1(8'hAA);
        push1(8'hBB);
        repeat (2) @(posedge CLK);
        #2;
        check_reset_outs("rst");

        // Single c1 packet, N=2: writes at T+1, T+3, T+5; idle at T+6.
        clear_logs();
        RESETn = 1'b1;
        wait_done(200);
        exp_q = '{8'h20, 8'hAA, 8'hBB};
        compare_out("single");
        t = hdr_cyc.size() > 0 ? hdr_cyc[0] : -100;
        check_eq("single_hdr_who", 32'(hdr_who.size() > 0 ? hdr_who[0] : 2'b00), 1);
        for (int i = 0; i < 3 && i < out_cyc.size(); i++) begin
            check_eq("single_wr_cyc", 32'(out_cyc[i]), 32'(t + 1 + 2 * i));
            check_eq("single_gnt", 32'(out_gnt[i]), 1);
        end
        check_eq("single_idle_cyc", 32'(idle_cyc.size() > 0 ? idle_cyc[0] : -1), 32'(t + 6));

        // Both clients preloaded out of reset: c1 wins first tie, then alternate.
        @(negedge CLK);
        #1;
        enter_reset();
        push1(8'h10); push1(8'h11); push1(8'h10); push1(8'h33);
        push2(8'h90); push2(8'h22); push2(8'h90); push2(8'h44);
        repeat (2) @(posedge CLK);
        clear_logs();
        at_pos();
        RESETn = 1'b1;
        wait_done(300);
        exp_q = '{8'h10, 8'h11, 8'h90, 8'h22, 8'h10, 8'h33, 8'h90, 8'h44};
        compare_out("rr");
        check_eq("rr_hdr_cnt", 32'(hdr_who.size()), 4);
        for (int i = 0; i < 4 && i < hdr_who.size(); i++) begin
            check_eq("rr_hdr_who", 32'(hdr_who[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // N=0 header on c2 after c1 finished last; then a tie must go to c1.
        clear_logs();
        at_pos();
        push1(8'h01);
        wait_done(100);
        at_pos();
        push2(8'h05);
        wait_done(100);
        at_pos();
        push1(8'h01);
        push2(8'h02);
        wait_done(100);
        exp_q = '{8'h01, 8'h05, 8'h01, 8'h02};
        compare_out("n0");
        if (hdr_cyc.size() >= 4 && out_cyc.size() >= 2 && idle_cyc.size() >= 2) begin
            check_eq("n0_wr_cyc", 32'(out_cyc[1]), 32'(hdr_cyc[1] + 1));
            check_eq("n0_busy", 32'(out_busy[1]), 1);
            check_eq("n0_idle_cyc", 32'(idle_cyc[1]), 32'(hdr_cyc[1] + 2));
            check_eq("n0_tie_first", 32'(hdr_who[2]), 1);
            check_eq("n0_tie_second", 32'(hdr_who[3]), 2);
        end else begin
            check_eq("n0_log_size", 32'(hdr_cyc.size()), 4);
        end

        // Mid-packet starvation: c1 stalls after its header while c2 has data.
        clear_logs();
        at_pos();
        push1(8'h30);
        wait_outs(1, 50);
        at_pos();
        push2(8'h90);
        push2(8'h22);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            #1;
            check_eq("starve_gnt", 32'(gnt), 1);
            check_eq("starve_c2_rden", 32'(c2_rden), 0);
            check_eq("starve_busy", 32'(busy), 1);
        end
        at_pos();
        push1(8'h31);
        push1(8'h32);
        push1(8'h33);
        wait_done(200);
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h90, 8'h22};
        compare_out("starve");
        check_eq("starve_who0", 32'(hdr_who.size() > 0 ? hdr_who[0] : 2'b00), 1);
        check_eq("starve_who1", 32'(hdr_who.size() > 1 ? hdr_who[1] : 2'b00), 2);

        // Output full: no grant in idle, then a 4-cycle stall mid-payload.
        clear_logs();
        at_pos();
        fifo_wrfull = 1'b1;
        push1(8'h20);
        push1(8'hAA);
        push1(8'hBB);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            check_eq("full_idle_gnt", 32'(gnt), 0);
            check_eq("full_idle_busy", 32'(busy), 0);
            check_eq("full_idle_rden", 32'(c1_rden), 0);
        end
        at_pos();
        fifo_wrfull = 1'b0;
        wait_outs(1, 50);
        at_pos();
        fifo_wrfull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            check_eq("stall_rden", 32'(c1_rden), 0);
            check_eq("stall_wren", 32'(fifo_wren), 0);
            check_eq("stall_gnt", 32'(gnt), 1);
        end
        at_pos();
        fifo_wrfull = 1'b0;
        wait_done(200);
        exp_q = '{8'h20, 8'hAA, 8'hBB};
        compare_out("stall");

        // Reset mid-payload: outputs drop at once; next word is a fresh header.
        clear_logs();
        at_pos();
        push1(8'h70);
        for (int i = 1; i <= 7; i++) push1(8'(8'hA0 + i));
        wait_outs(4, 100);
        enter_reset();
        push1(8'h55); // data left in the client must not be read while reset is held
        #1;
        check_reset_outs("midrst");
        enter_reset();
        repeat (2) @(posedge CLK);
        push1(8'h00);
        push1(8'h10);
        push1(8'h11);
        clear_logs();
        at_pos();
        RESETn = 1'b1;
        wait_done(200);
        exp_q = '{8'h00, 8'h10, 8'h11};
        compare_out("post_rst");
        if (hdr_cyc.size() >= 1 && idle_cyc.size() >= 1) begin
            check_eq("post_rst_idle", 32'(idle_cyc[0]), 32'(hdr_cyc[0] + 2));
        end else begin
            check_eq("post_rst_log", 32'(hdr_cyc.size()), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
